// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative DIV/DIVU unit.
package div_unit_pkg;
  localparam int DATA_W     = 32;
  localparam int DIV_CYCLES = 32;
  localparam int CNT_W      = $clog2(DIV_CYCLES);

  typedef logic [DATA_W-1:0] word_t;
  typedef logic              bit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } div_state_t;
endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step on unsigned magnitudes (combinational).
module div_step
  import div_unit_pkg::*;
(
  input  word_t rem,
  input  word_t quo,
  input  word_t dvs,
  output word_t rem_nxt,
  output word_t quo_nxt
);
  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] diff;
  logic              fits;

  // Partial remainder is always below the divisor, so the trial never exceeds 33 bits.
  assign trial   = {rem, quo[DATA_W-1]};
  assign fits    = trial >= {1'b0, dvs};
  assign diff    = trial[DATA_W-1:0] - dvs;
  assign rem_nxt = fits ? diff : trial[DATA_W-1:0];
  assign quo_nxt = {quo[DATA_W-2:0], fits};
endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit DIV/DIVU unit: accept, 32 restoring steps, one-cycle ready.
// Define DIV_ZERO_FAST_EN to finish divide-by-zero in the cycle after accept.
module div_unit
  import div_unit_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  bit_t  start,
  input  bit_t  signed_div,
  input  word_t dividend,
  input  word_t divisor,
  input  bit_t  flush,
  output word_t result_lo,
  output word_t result_hi,
  output bit_t  ready,
  output bit_t  ex_stall_req
);
  div_state_t       state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q;
  word_t            rem_q, quo_q, dvs_q;
  word_t            rem_nxt, quo_nxt;
  logic             neg_quo_q, neg_rem_q;
  logic             accept, last_step, fast_zero;

  function automatic word_t abs_val(input word_t v, input bit_t sgn);
    logic signed [DATA_W-1:0] sv;
    sv = signed'(v);
    return (sgn && sv < 0) ? word_t'(-sv) : v;
  endfunction

  function automatic word_t neg_if(input word_t v, input bit_t neg);
    logic signed [DATA_W-1:0] sv;
    sv = signed'(v);
    return neg ? word_t'(-sv) : v;
  endfunction

`ifdef DIV_ZERO_FAST_EN
  assign fast_zero = (divisor == '0);
`else
  assign fast_zero = 1'b0;
`endif

  assign accept    = (state_q == IDLE) && start && !flush;
  assign last_step = (cnt_q == CNT_W'(DIV_CYCLES - 1));

  div_step u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .dvs     (dvs_q),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_nxt = fast_zero ? DONE : DIV;
      DIV:     if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_comb begin
    ready        = 1'b0;
    ex_stall_req = 1'b0;
    if (!rst) begin
      ready        = (state_q == DONE) && !flush;
      ex_stall_req = accept || (state_q == DIV);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                   cnt_q <= '0;
    else if (accept)           cnt_q <= '0;
    else if (state_q == DIV)   cnt_q <= cnt_q + 1'b1;
  end

  // Operands are captured as magnitudes; sign fixup is applied only on the way out.
  always_ff @(posedge clk) begin
    if (accept) begin
      rem_q     <= '0;
      quo_q     <= abs_val(dividend, signed_div);
      dvs_q     <= abs_val(divisor, signed_div);
      neg_quo_q <= signed_div && (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
      neg_rem_q <= signed_div && dividend[DATA_W-1];
    end else if (state_q == DIV) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_lo <= '0;
      result_hi <= '0;
    end else if (!flush) begin
      if (accept && fast_zero) begin
        result_lo <= '1;
        result_hi <= dividend;
      end else if (state_q == DIV && last_step) begin
        result_lo <= neg_if(quo_nxt, neg_quo_q);
        result_hi <= neg_if(rem_nxt, neg_rem_q);
      end
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed DIV/DIVU cases, flush, reset and back-to-back.
`timescale 1ns/1ps
module tb_div_unit;
  import div_unit_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  bit_t  start, signed_div, flush;
  word_t dividend, divisor;
  word_t result_lo, result_hi;
  bit_t  ready, ex_stall_req;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    word_t lo;
    word_t hi;
  } exp_t;
  exp_t sb[$];

`ifdef DIV_ZERO_FAST_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 33;
`endif

  always #5 clk = ~clk;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .signed_div   (signed_div),
    .dividend     (dividend),
    .divisor      (divisor),
    .flush        (flush),
    .result_lo    (result_lo),
    .result_hi    (result_hi),
    .ready        (ready),
    .ex_stall_req (ex_stall_req)
  );

  function automatic exp_t model(input bit s, input word_t a, input word_t b);
    exp_t  e;
    word_t ma, mb, q, r;
    ma = (s && a[31]) ? (~a + 32'd1) : a;
    mb = (s && b[31]) ? (~b + 32'd1) : b;
    if (mb == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = ma;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    if (s && (a[31] ^ b[31])) q = ~q + 32'd1;
    if (s && a[31])           r = ~r + 32'd1;
`ifdef DIV_ZERO_FAST_EN
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end
`endif
    e.lo = q;
    e.hi = r;
    return e;
  endfunction

  function automatic int exp_lat(input word_t b);
    return (b == 32'd0) ? ZERO_LAT : 33;
  endfunction

  // Called at a negedge with the DUT in IDLE; returns at the negedge of the ready cycle.
  task automatic issue(input bit s, input word_t a, input word_t b, input bit scramble,
                       output int lat, output int stalls, output bit stall_rdy,
                       output word_t lo, output word_t hi);
    signed_div = s;
    dividend   = a;
    divisor    = b;
    start      = 1'b1;
    sb.push_back(model(s, a, b));
    #1;
    stalls    = ex_stall_req ? 1 : 0;
    stall_rdy = 1'b0;
    lat       = -1;
    lo        = '0;
    hi        = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ready) begin
        lat       = k;
        lo        = result_lo;
        hi        = result_hi;
        stall_rdy = ex_stall_req;
        break;
      end
      if (ex_stall_req) stalls++;
      if (scramble) begin
        dividend   = $urandom;
        divisor    = $urandom;
        signed_div = ~s;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; flush = 1'b0;
    signed_div = 1'b0; dividend = 32'd100; divisor = 32'd7;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (ex_stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%0b want=0", ex_stall_req); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%0b want=0", ready); end
    n_checks++; if (result_lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo got=%h want=0", result_lo); end
    n_checks++; if (result_hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi got=%h want=0", result_hi); end
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_divu_basic();
    int lat, stalls; bit srdy; word_t lo, hi; exp_t e;
    issue(1'b0, 32'd100, 32'd7, 1'b1, lat, stalls, srdy, lo, hi);
    e = sb.pop_front();
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL divu_latency got=%0d want=33", lat); end
    n_checks++; if (stalls !== 33) begin n_fail++; $display("FAIL divu_stall_cycles got=%0d want=33", stalls); end
    n_checks++; if (srdy !== 1'b0) begin n_fail++; $display("FAIL divu_stall_in_done got=%0b want=0", srdy); end
    n_checks++; if (lo !== e.lo) begin n_fail++; $display("FAIL divu_lo got=%h want=%h", lo, e.lo); end
    n_checks++; if (hi !== e.hi) begin n_fail++; $display("FAIL divu_hi got=%h want=%h", hi, e.hi); end
    @(negedge clk);
    n_checks++; if (result_lo !== e.lo) begin n_fail++; $display("FAIL divu_lo_hold got=%h want=%h", result_lo, e.lo); end
  endtask

  task automatic test_signed();
    word_t ta [4] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd7,       32'hFFFF_FFF9};
    word_t tb [4] = '{32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    int lat, stalls; bit srdy; word_t lo, hi; exp_t e;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, ta[i], tb[i], 1'b0, lat, stalls, srdy, lo, hi);
      e = sb.pop_front();
      n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL signed_latency[%0d] got=%0d want=33", i, lat); end
      n_checks++; if (lo !== e.lo) begin n_fail++; $display("FAIL signed_lo[%0d] got=%h want=%h", i, lo, e.lo); end
      n_checks++; if (hi !== e.hi) begin n_fail++; $display("FAIL signed_hi[%0d] got=%h want=%h", i, hi, e.hi); end
      @(negedge clk);
    end
  endtask

  task automatic test_div_zero();
    bit    ts [2] = '{1'b0, 1'b1};
    word_t ta [2] = '{32'd5, 32'hFFFF_FFFB};
    int lat, stalls; bit srdy; word_t lo, hi; exp_t e;
    for (int i = 0; i < 2; i++) begin
      issue(ts[i], ta[i], 32'd0, 1'b1, lat, stalls, srdy, lo, hi);
      e = sb.pop_front();
      n_checks++; if (lat !== ZERO_LAT) begin n_fail++; $display("FAIL zero_latency[%0d] got=%0d want=%0d", i, lat, ZERO_LAT); end
      n_checks++; if (stalls !== ZERO_LAT) begin n_fail++; $display("FAIL zero_stalls[%0d] got=%0d want=%0d", i, stalls, ZERO_LAT); end
      n_checks++; if (lo !== e.lo) begin n_fail++; $display("FAIL zero_lo[%0d] got=%h want=%h", i, lo, e.lo); end
      n_checks++; if (hi !== e.hi) begin n_fail++; $display("FAIL zero_hi[%0d] got=%h want=%h", i, hi, e.hi); end
      @(negedge clk);
    end
  endtask

  task automatic test_flush();
    int lat, stalls, n_rdy; bit srdy; word_t lo, hi, prev_lo, prev_hi; exp_t e;
    prev_lo = result_lo;
    prev_hi = result_hi;
    signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    flush = 1'b1;
    #1;
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got=%0b want=0", ready); end
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    n_checks++; if (ex_stall_req !== 1'b0) begin n_fail++; $display("FAIL flush_idle_stall got=%0b want=0", ex_stall_req); end
    n_checks++; if (result_lo !== prev_lo) begin n_fail++; $display("FAIL flush_lo_kept got=%h want=%h", result_lo, prev_lo); end
    n_checks++; if (result_hi !== prev_hi) begin n_fail++; $display("FAIL flush_hi_kept got=%h want=%h", result_hi, prev_hi); end
    issue(1'b0, 32'd1000, 32'd3, 1'b0, lat, stalls, srdy, lo, hi);
    e = sb.pop_front();
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL after_flush_latency got=%0d want=33", lat); end
    n_checks++; if (lo !== e.lo) begin n_fail++; $display("FAIL after_flush_lo got=%h want=%h", lo, e.lo); end
    @(negedge clk);
    // A flush arriving with start must win.
    start = 1'b1; flush = 1'b1; dividend = 32'd50; divisor = 32'd5;
    #1;
    n_checks++; if (ex_stall_req !== 1'b0) begin n_fail++; $display("FAIL flush_vs_start_stall got=%0b want=0", ex_stall_req); end
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    n_checks++; if (ex_stall_req !== 1'b0) begin n_fail++; $display("FAIL flush_vs_start_idle got=%0b want=0", ex_stall_req); end
    n_rdy = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready) n_rdy++;
    end
    n_checks++; if (n_rdy !== 0) begin n_fail++; $display("FAIL flush_vs_start_ready got=%0d want=0", n_rdy); end
  endtask

  task automatic test_back_to_back();
    int lat, stalls; bit srdy; word_t lo, hi; exp_t e;
    for (int i = 0; i < 2; i++) begin
      issue(1'b0, 32'd9, 32'd4, 1'b0, lat, stalls, srdy, lo, hi);
      e = sb.pop_front();
      n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL b2b_latency[%0d] got=%0d want=33", i, lat); end
      n_checks++; if (lo !== e.lo) begin n_fail++; $display("FAIL b2b_lo[%0d] got=%h want=%h", i, lo, e.lo); end
      n_checks++; if (hi !== e.hi) begin n_fail++; $display("FAIL b2b_hi[%0d] got=%h want=%h", i, hi, e.hi); end
      @(negedge clk);
    end
  endtask

  task automatic test_rst_mid();
    int n_rdy;
    signed_div = 1'b0; dividend = 32'd77; divisor = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (ex_stall_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall got=%0b want=0", ex_stall_req); end
    n_checks++; if (result_lo !== 32'd0) begin n_fail++; $display("FAIL rst_mid_lo got=%h want=0", result_lo); end
    n_rdy = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready) n_rdy++;
    end
    n_checks++; if (n_rdy !== 0) begin n_fail++; $display("FAIL rst_mid_ready got=%0d want=0", n_rdy); end
  endtask

  task automatic test_random();
    int lat, stalls; bit srdy, s; word_t a, b, lo, hi; exp_t e;
    for (int i = 0; i < 10; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? word_t'($urandom_range(1, 20)) : word_t'($urandom);
      if ($urandom_range(0, 1) == 1) b = -b;
      issue(s, a, b, 1'b1, lat, stalls, srdy, lo, hi);
      e = sb.pop_front();
      n_checks++; if (lat !== exp_lat(b)) begin n_fail++; $display("FAIL rand_latency[%0d] got=%0d want=%0d", i, lat, exp_lat(b)); end
      n_checks++; if (lo !== e.lo) begin n_fail++; $display("FAIL rand_lo[%0d] s=%0b a=%h b=%h got=%h want=%h", i, s, a, b, lo, e.lo); end
      n_checks++; if (hi !== e.hi) begin n_fail++; $display("FAIL rand_hi[%0d] s=%0b a=%h b=%h got=%h want=%h", i, s, a, b, hi, e.hi); end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    signed_div = 1'b0; dividend = '0; divisor = '0;
    @(negedge clk);
    test_reset();
    test_divu_basic();
    test_signed();
    test_div_zero();
    test_flush();
    test_back_to_back();
    test_rst_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port start  input  bit_t  EX-stage divide request, held high while the DIV/DIVU instruction sits in EX.
REQ-004 SHALL have port signed_div  input  bit_t  1 = DIV (two's complement), 0 = DIVU.
REQ-005 SHALL have port dividend  input  word_t  forwarded operand rs (true_gpr_rdata1 path).
REQ-006 SHALL have port divisor  input  word_t  forwarded operand rt (true_gpr_rdata2 path).
REQ-007 SHALL have port flush  input  bit_t  pipeline flush (exception/eret); cancels any operation.
REQ-008 SHALL have port result_lo  output  word_t  quotient, for the LO write.
REQ-009 SHALL have port result_hi  output  word_t  remainder, for the HI write.
REQ-010 SHALL have port ready  output  bit_t  one-cycle pulse; result_lo/result_hi valid.
REQ-011 SHALL have port ex_stall_req  output  bit_t  EX stall request to the pipeline controller.

Function
REQ-012 SHALL implement FSM states IDLE, DIV, DONE; reset state IDLE.
REQ-013 IDLE: start=1 and flush=0 -> latch signed_div, dividend, divisor; load counter 0; go DIV. Later operand changes are ignored.
REQ-014 DIV: one radix-2 restoring step per cycle on 32-bit magnitudes; after 32 steps (counter 31) go DONE.
REQ-015 Latency: accept in cycle T; DIV spans T+1..T+32; DONE and ready=1 in T+33.
REQ-016 DONE: ready=1 for exactly one cycle, then IDLE unconditionally; start in DONE is not accepted.
REQ-017 ex_stall_req SHALL be combinational: (IDLE and start and !flush) or DIV; 0 in DONE, so the instruction advances in the ready cycle.
REQ-018 Signed: divide |dividend| by |divisor|; negate quotient if operand signs differ; remainder takes dividend's sign.
REQ-019 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0; no trap.
REQ-020 result_lo/result_hi SHALL hold their last value outside DONE; they are updated only on entry to DONE.
REQ-021 flush=1 in any state -> IDLE next cycle; ready=0 that cycle; no result update; flush wins over a simultaneous start.
REQ-022 Back-to-back divides: a new start in the cycle after DONE (state IDLE) SHALL be accepted normally.

Reset
REQ-023 rst=1 -> state IDLE, counter 0, result_lo=0, result_hi=0, ready=0; ex_stall_req=0 while rst=1.
REQ-024 rst mid-DIV SHALL abandon the operation; no ready pulse follows.

Configuration
REQ-025 Macro DIV_ZERO_FAST_EN defined: divisor==0 at accept -> go directly IDLE->DONE (ready at T+1), lo=0xFFFFFFFF, hi=dividend (raw), regardless of signed_div.
REQ-026 Macro undefined: divisor==0 takes the full 33 cycles; unsigned yields lo=0xFFFFFFFF, hi=dividend; signed applies REQ-018 fixup to those magnitudes.

Structure
REQ-027 word_t, bit_t, the div_state_t enum and constant DIV_CYCLES=32 SHALL live in the shared defines package.
REQ-028 The per-cycle subtract/shift SHALL be a combinational sub-module div_step (partial remainder, quotient, divisor in; next partial remainder and quotient out).

Verification
REQ-029 DIVU 100/7, start held -> ex_stall_req 1 for 33 cycles, ready at T+33, lo=14, hi=2.
REQ-030 DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF at T+33.
REQ-031 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-032 DIVU 5/0 -> with DIV_ZERO_FAST_EN ready at T+1; without, at T+33; both lo=0xFFFFFFFF, hi=5.
REQ-033 flush at T+10 -> IDLE at T+11, no ready, prior results unchanged; a new start at T+11 completes at T+44.
REQ-034 Two DIVU 9/4 back-to-back (second start at T+34) -> ready at T+33 and T+67, lo=2, hi=1 each time.
